regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Shares the single register-file write port between two writeback requesters, the ALU and the load unit.
- Keeps a per-register busy scoreboard so the issue stage stalls on pending writes (RAW and WAW hazards).
- Sits between the execute/memory stages and the register file. Drives the register file's rd, writeData and RegWrite inputs from registered outputs.

Parameters:
- REG_ADDR_W, 5: register address width; the design has 2^REG_ADDR_W registers.
- VALUE_W, 32: data width.
- STARVE_MAX, 3: number of consecutive lost arbitrations after which the ALU takes priority.

Ports:
- clock  in  1  system clock
- reset  in  1  async, active-low
- alu_valid  in  1  ALU writeback request
- alu_rd  in  REG_ADDR_W  ALU destination
- alu_data  in  VALUE_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- ld_valid  in  1  load writeback request
- ld_rd  in  REG_ADDR_W  load destination
- ld_data  in  VALUE_W  load result
- ld_ready  out  1  load request accepted this cycle (combinational)
- issue_valid  in  1  instruction attempting issue
- issue_rs1, issue_rs2, issue_rd  in  REG_ADDR_W  issuing instruction's sources and destination
- issue_writes  in  1  issuing instruction writes rd
- issue_stall  out  1  hazard; issue must hold (combinational)
- rf_rd  out  REG_ADDR_W  to register file rd (registered)
- rf_writeData  out  VALUE_W  to register file writeData (registered)
- rf_RegWrite  out  1  to register file RegWrite (registered)

Behaviour:
- Reset (async, active-low): rf_RegWrite=0, rf_rd=0, rf_writeData=0, all busy bits=0, starve counter=0. A reset asserted mid-operation drops any pending writes.
- Handshake: a request is accepted in a cycle where valid && ready. Requesters hold rd and data stable until accepted.
- Requests with rd==0 get ready=1 immediately, never use the port and never touch the scoreboard. Both requesters can therefore be accepted in the same cycle if one targets x0.
- Arbitration, among requests with rd!=0:
  - Only one requester present: that requester is granted.
  - Both present: the load wins, unless the starve counter == STARVE_MAX, in which case the ALU wins.
- Starve counter: increments (saturating at STARVE_MAX) each cycle alu_valid is held with rd!=0 and not granted. Clears on any ALU grant. Holds when alu_valid=0.
- Write latency: grant in cycle N loads rf_rd/rf_writeData and sets rf_RegWrite=1 at the posedge ending N. The register file commits on the falling edge of cycle N+1. rf_RegWrite=0 in any cycle following a cycle with no grant.
- Scoreboard: one busy bit per register; busy[0] is hard-wired 0.
  - Set busy[issue_rd] at the posedge when issue_valid && !issue_stall && issue_writes && issue_rd!=0.
  - Clear busy[rd] at the posedge when a write for rd is granted.
  - Set and clear of the same register at the same edge: set wins (a new producer overrides).
- issue_stall = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || (issue_writes && busy[issue_rd])).
- Requesters must only write registers that are marked busy. A grant to a non-busy register with rd!=0 still writes; the scoreboard is unchanged.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: a source hazard (rs1 or rs2) is suppressed when the register is being granted for write in the same cycle.
  - Issue proceeds in cycle N, and the register file read at posedge N+2 sees the committed value.
  - WAW hazards on issue_rd still stall.
- Undefined: no suppression. Issue waits for busy to clear, costing one extra stall cycle per RAW hazard.

Test Plan:
- Reset, then a single ALU request rd=5 data=0xDEADBEEF -> alu_ready=1 in cycle 0; rf_RegWrite=1, rf_rd=5, rf_writeData=0xDEADBEEF in cycle 1; rf_RegWrite=0 in cycle 2.
- ALU and load both valid continuously with rd=3 and rd=4 -> grant order L,L,L,A,L,L,L,A (STARVE_MAX=3); starve counter returns to 0 after each ALU grant.
- ALU rd=0 and load rd=7 in the same cycle -> both ready=1; only rd=7 is written.
- Issue rd=9 accepted, then issue rs1=9 -> stall until the rd=9 write is granted. Without the bypass macro, the stall drops the cycle after the grant; with REGFILE_WB_BYPASS_EN, it drops in the grant cycle.
- A write to rd=6 is granted while a new issue with rd=6 is accepted in the same cycle -> busy[6] remains 1; a subsequent rs2=6 issue stalls.
- Reset asserted while busy bits are set and a grant is outstanding -> all outputs and busy bits are 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single register-file write port between the ALU and the load unit
// and tracks per-register busy bits for issue hazards. Optional: REGFILE_WB_BYPASS_EN.
module regfile_write_scheduler #(
  parameter int REG_ADDR_W = 5,
  parameter int VALUE_W    = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [VALUE_W-1:0]    i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_ld_valid,
  input  logic [REG_ADDR_W-1:0] i_ld_rd,
  input  logic [VALUE_W-1:0]    i_ld_data,
  output logic                  o_ld_ready,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rs1,
  input  logic [REG_ADDR_W-1:0] i_issue_rs2,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_issue_writes,
  output logic                  o_issue_stall,
  output logic [REG_ADDR_W-1:0] o_rf_rd,
  output logic [VALUE_W-1:0]    o_rf_writeData,
  output logic                  o_rf_RegWrite
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

  logic [NREG-1:0]       r_busy;
  logic [SW-1:0]         r_starve;
  logic                  w_alu_req;
  logic                  w_ld_req;
  logic                  w_grant_alu;
  logic                  w_grant_ld;
  logic                  w_grant;
  logic [REG_ADDR_W-1:0] w_grant_rd;
  logic [VALUE_W-1:0]    w_grant_data;
  logic [NREG-1:0]       w_clr_mask;
  logic [NREG-1:0]       w_set_mask;
  logic [NREG-1:0]       w_src_busy;

  // Writes to x0 are accepted outright and never compete for the port.
  assign w_alu_req    = i_alu_valid && (i_alu_rd != '0);
  assign w_ld_req     = i_ld_valid && (i_ld_rd != '0);
  assign w_grant_alu  = w_alu_req && (!w_ld_req || (r_starve == STARVE_LIMIT));
  assign w_grant_ld   = w_ld_req && !w_grant_alu;
  assign w_grant      = w_grant_alu || w_grant_ld;
  assign w_grant_rd   = w_grant_alu ? i_alu_rd : i_ld_rd;
  assign w_grant_data = w_grant_alu ? i_alu_data : i_ld_data;

  assign o_alu_ready = i_alu_valid && ((i_alu_rd == '0) || w_grant_alu);
  assign o_ld_ready  = i_ld_valid && ((i_ld_rd == '0) || w_grant_ld);

  always_comb begin
    w_clr_mask = '0;
    if (w_grant) w_clr_mask[w_grant_rd] = 1'b1;
  end

`ifdef REGFILE_WB_BYPASS_EN
  // A source being written this cycle is readable by the time the issued op reads it.
  assign w_src_busy = r_busy & ~w_clr_mask;
`else
  assign w_src_busy = r_busy;
`endif

  assign o_issue_stall = i_issue_valid &&
                         (w_src_busy[i_issue_rs1] || w_src_busy[i_issue_rs2] ||
                          (i_issue_writes && r_busy[i_issue_rd]));

  always_comb begin
    w_set_mask = '0;
    if (i_issue_valid && !o_issue_stall && i_issue_writes && (i_issue_rd != '0))
      w_set_mask[i_issue_rd] = 1'b1;
  end

  // Set has priority over clear so a fresh producer keeps the register busy.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign r_busy[gi] = 1'b0;
      end else begin : g_bit
        always_ff @(posedge clock or negedge reset) begin
          if (!reset)                r_busy[gi] <= 1'b0;
          else if (w_set_mask[gi])   r_busy[gi] <= 1'b1;
          else if (w_clr_mask[gi])   r_busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (w_grant_alu) begin
      r_starve <= '0;
    end else if (w_alu_req && (r_starve != STARVE_LIMIT)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_rf_RegWrite  <= 1'b0;
      o_rf_rd        <= '0;
      o_rf_writeData <= '0;
    end else begin
      o_rf_RegWrite <= w_grant;
      if (w_grant) begin
        o_rf_rd        <= w_grant_rd;
        o_rf_writeData <= w_grant_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Table-driven bench for regfile_write_scheduler with a write-port scoreboard queue.
module tb_regfile_write_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, issue_valid = 1'b0, issue_writes = 1'b0;
  logic [4:0]  alu_rd = '0, ld_rd = '0, rs1 = '0, rs2 = '0, ird = '0;
  logic [31:0] alu_data = '0, ld_data = '0;
  logic        alu_ready, ld_ready, stall, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;

  int n_cmp = 0;
  int n_err = 0;

`ifdef REGFILE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  always #5 clock = ~clock;

  regfile_write_scheduler dut (
    .clock(clock), .reset(reset),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
    .i_ld_valid(ld_valid), .i_ld_rd(ld_rd), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .i_issue_valid(issue_valid), .i_issue_rs1(rs1), .i_issue_rs2(rs2), .i_issue_rd(ird),
    .i_issue_writes(issue_writes), .o_issue_stall(stall),
    .o_rf_rd(rf_rd), .o_rf_writeData(rf_wd), .o_rf_RegWrite(rf_we)
  );

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic lv; logic [4:0] lrd; logic [31:0] ldat;
    logic iv; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] ird; logic iw;
    logic e_ar; logic e_lr; logic e_st;
    logic e_wr; logic [4:0] e_rd; logic [31:0] e_dat;
  } vec_t;

  typedef struct { logic wr; logic [4:0] rd; logic [31:0] dat; } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];

  function automatic vec_t mk(input logic av, input int ard, input logic [31:0] adat,
                              input logic lv, input int lrd, input logic [31:0] ldat,
                              input logic iv, input int r1, input int r2, input int rd, input logic iw,
                              input logic ear, input logic elr, input logic est,
                              input logic ewr, input int erd, input logic [31:0] edat);
    vec_t v;
    v.av = av; v.ard = 5'(ard); v.adat = adat;
    v.lv = lv; v.lrd = 5'(lrd); v.ldat = ldat;
    v.iv = iv; v.rs1 = 5'(r1); v.rs2 = 5'(r2); v.ird = 5'(rd); v.iw = iw;
    v.e_ar = ear; v.e_lr = elr; v.e_st = est;
    v.e_wr = ewr; v.e_rd = 5'(erd); v.e_dat = edat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    wr_t w;
    @(negedge clock);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
    ld_valid = v.lv; ld_rd = v.lrd; ld_data = v.ldat;
    issue_valid = v.iv; rs1 = v.rs1; rs2 = v.rs2; ird = v.ird; issue_writes = v.iw;
    #1;
    chk($sformatf("v%0d alu_ready", idx), 32'(alu_ready), 32'(v.e_ar));
    chk($sformatf("v%0d ld_ready", idx), 32'(ld_ready), 32'(v.e_lr));
    chk($sformatf("v%0d issue_stall", idx), 32'(stall), 32'(v.e_st));
    exp_q.push_back('{wr: v.e_wr, rd: v.e_rd, dat: v.e_dat});
    @(posedge clock);
    #1;
    w = exp_q.pop_front();
    chk($sformatf("v%0d rf_RegWrite", idx), 32'(rf_we), 32'(w.wr));
    if (w.wr) begin
      chk($sformatf("v%0d rf_rd", idx), 32'(rf_rd), 32'(w.rd));
      chk($sformatf("v%0d rf_writeData", idx), rf_wd, w.dat);
    end
    $display("vec %0d: ar=%b lr=%b stall=%b we=%b rd=%0d data=%h", idx, v.e_ar, v.e_lr, v.e_st,
             rf_we, rf_rd, rf_wd);
  endtask

  initial begin
    // rows 0-1: single ALU write, then idle
    vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0,0,0,0, 1,0,0, 1,5,32'hDEADBEEF));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0));
    // rows 2-9: contention, expected L,L,L,A,L,L,L,A
    for (int k = 0; k < 8; k++) begin
      if (k == 3 || k == 7)
        vecs.push_back(mk(1,3,32'hA3, 1,4,32'h14, 0,0,0,0,0, 1,0,0, 1,3,32'hA3));
      else
        vecs.push_back(mk(1,3,32'hA3, 1,4,32'h14, 0,0,0,0,0, 0,1,0, 1,4,32'h14));
    end
    // row 10: ALU to x0 alongside load to r7
    vecs.push_back(mk(1,0,32'h55, 1,7,32'h77, 0,0,0,0,0, 1,1,0, 1,7,32'h77));
    // rows 11-14: RAW on r9
    vecs.push_back(mk(0,0,0, 0,0,0, 1,1,2,9,1, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,9,0,0,0, 0,0,1, 0,0,0));
    vecs.push_back(mk(1,9,32'h99, 0,0,0, 1,9,0,0,0, 1,0,!BYP, 1,9,32'h99));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,9,0,0,0, 0,0,0, 0,0,0));
    // rows 15-18: set and clear of r6 on the same edge
    vecs.push_back(mk(0,0,0, 1,6,32'h66, 1,0,0,6,1, 0,1,0, 1,6,32'h66));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0,6,0,0, 0,0,1, 0,0,0));
    vecs.push_back(mk(1,6,32'hAB, 0,0,0, 0,0,0,0,0, 1,0,0, 1,6,32'hAB));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0,6,0,0, 0,0,0, 0,0,0));
    // rows 19-22: r10 busy, RAW and WAW stalls, then write r10 while r11 issues
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,10,1, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,10,0,0,0, 0,0,1, 0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,10,1, 0,0,1, 0,0,0));
    vecs.push_back(mk(1,10,32'h10, 0,0,0, 1,0,0,11,1, 1,0,0, 1,10,32'h10));

    // reset state
    issue_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset rf_RegWrite", 32'(rf_we), 32'd0);
    chk("reset rf_rd", 32'(rf_rd), 32'd0);
    chk("reset rf_writeData", rf_wd, 32'd0);
    chk("reset issue_stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // asynchronous reset with r11 busy and a write of r10 on the port
    alu_valid = 1'b0; ld_valid = 1'b0;
    issue_valid = 1'b1; rs1 = 5'd11; rs2 = 5'd0; ird = 5'd0; issue_writes = 1'b0;
    #1;
    chk("pre-reset issue_stall", 32'(stall), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async reset rf_RegWrite", 32'(rf_we), 32'd0);
    chk("async reset rf_rd", 32'(rf_rd), 32'd0);
    chk("async reset rf_writeData", rf_wd, 32'd0);
    chk("async reset issue_stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post-reset issue_stall", 32'(stall), 32'd0);
    $display("reset sequence: stall=%b we=%b", stall, rf_we);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
